// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl -- sequencer for the 8x8 systolic-array TPU datapath.
//
// On an accepted tpu_start it walks a run counter (cnt) through 0..LAST.
// The counter drives one shared read address for the four input SRAMs and
// the writeback windows of the three output SRAMs (batches 0/1/2 -> a/b/c).
// All outputs are registered from the next-state values, so in every RUN
// cycle the address/strobe outputs describe the cnt value held that cycle.
//
// Ports:
//   clk, srstn             clock (rising edge), async active-low reset
//   tpu_start              one-cycle start pulse (ignored while busy)
//   stall                  freeze request from the datapath
//   sram_raddr_w0/w1/d0/d1 shared input-SRAM read address
//   feed_valid             read data on the input SRAMs is a feed word
//   sram_write_enable_*0   active-low write strobes, batches 0/1/2
//   sram_waddr_a/b/c       output write address (also diagonal select)
//   busy                   run in progress
//   tpu_done               level, set at end of run, cleared by next start
//   perf_cycles            run length in cycles
//
// Optional feature macro: TPU_SEQ_PERF_EN builds the run-length counter;
// without it perf_cycles is tied to zero.
module tpu_seq_ctrl #(
  parameter int ARRAY_SIZE = 8,
  parameter int BATCH      = 3,
  parameter int SKEW       = 3,
  parameter int WB_START   = 11,
  parameter int IN_AW      = 10,
  parameter int OUT_AW     = 6
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              tpu_start,
  input  logic              stall,
  output logic [IN_AW-1:0]  sram_raddr_w0,
  output logic [IN_AW-1:0]  sram_raddr_w1,
  output logic [IN_AW-1:0]  sram_raddr_d0,
  output logic [IN_AW-1:0]  sram_raddr_d1,
  output logic              feed_valid,
  output logic              sram_write_enable_a0,
  output logic              sram_write_enable_b0,
  output logic              sram_write_enable_c0,
  output logic [OUT_AW-1:0] sram_waddr_a,
  output logic [OUT_AW-1:0] sram_waddr_b,
  output logic [OUT_AW-1:0] sram_waddr_c,
  output logic              busy,
  output logic              tpu_done,
  output logic [15:0]       perf_cycles
);

  localparam int FEED_LEN = ARRAY_SIZE * BATCH + SKEW;
  localparam int DIAG     = 2 * ARRAY_SIZE - 1;
  localparam int LAST     = WB_START + (BATCH - 1) * ARRAY_SIZE + DIAG - 1;
  localparam int CW       = $clog2(LAST + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              start_acc_s;
  logic              freeze_s;
  logic [IN_AW-1:0]  raddr_r;
  logic              feed_valid_r;
  logic [2:0]        we_n_r;
  logic [OUT_AW-1:0] waddr_r [3];
  logic              busy_r;
  logic              done_r;

  // True when cnt lies inside the 15-row writeback window of batch b.
  function automatic logic in_win(input logic [CW-1:0] c, input int b);
    int lo;
    lo = WB_START + ARRAY_SIZE * b;
    return (int'(c) >= lo) && (int'(c) < lo + DIAG);
  endfunction

  // Diagonal row index of batch b for counter value c.
  function automatic logic [OUT_AW-1:0] wb_addr(input logic [CW-1:0] c, input int b);
    return OUT_AW'(int'(c) - (WB_START + ARRAY_SIZE * b));
  endfunction

  // State and run-counter register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: a stall in RUN freezes everything, start is only
  // accepted from IDLE or DONE.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    start_acc_s = 1'b0;
    freeze_s    = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (tpu_start) begin
          state_s     = S_RUN;
          cnt_s       = '0;
          start_acc_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (stall) begin
          freeze_s = 1'b1;
        end else if (cnt_r == CW'(LAST)) begin
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output registers, computed from next-state values so they line up with
  // the cnt of the cycle they appear in. A frozen edge keeps cnt, hence the
  // read address, and blocks every write strobe so no row is written twice.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      raddr_r      <= '0;
      feed_valid_r <= 1'b0;
      we_n_r       <= 3'b111;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      for (int b = 0; b < 3; b++) begin
        waddr_r[b] <= '0;
      end
    end else begin
      busy_r  <= (state_s == S_RUN);
      raddr_r <= ((state_s == S_RUN) && (int'(cnt_s) < FEED_LEN)) ? IN_AW'(cnt_s) : '0;
      // Read latency is one cycle: the word addressed now is valid next cycle.
      feed_valid_r <= (state_r == S_RUN) && !stall && (int'(cnt_r) < FEED_LEN);
      for (int b = 0; b < 3; b++) begin
        if ((state_s == S_RUN) && !freeze_s && in_win(cnt_s, b)) begin
          we_n_r[b]  <= 1'b0;
          waddr_r[b] <= wb_addr(cnt_s, b);
        end else begin
          we_n_r[b]  <= 1'b1;
        end
      end
      if (start_acc_s) begin
        done_r <= 1'b0;
      end else if (state_r == S_DONE) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] perf_cnt_r;
  logic [15:0] perf_cycles_r;

  // Run-length counter: counts every RUN cycle, stalled or not, saturating.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      perf_cnt_r <= 16'h0000;
    end else if (start_acc_s) begin
      perf_cnt_r <= 16'h0000;
    end else if ((state_r == S_RUN) && (perf_cnt_r != 16'hFFFF)) begin
      perf_cnt_r <= perf_cnt_r + 16'h0001;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  // Snapshot of the run length, taken in DONE alongside tpu_done.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      perf_cycles_r <= 16'h0000;
    end else if (state_r == S_DONE) begin
      perf_cycles_r <= perf_cnt_r;
    end else begin
      perf_cycles_r <= perf_cycles_r;
    end
  end

  assign perf_cycles = perf_cycles_r;
`else
  assign perf_cycles = 16'h0000;
`endif

  assign sram_raddr_w0        = raddr_r;
  assign sram_raddr_w1        = raddr_r;
  assign sram_raddr_d0        = raddr_r;
  assign sram_raddr_d1        = raddr_r;
  assign feed_valid           = feed_valid_r;
  assign sram_write_enable_a0 = we_n_r[0];
  assign sram_write_enable_b0 = we_n_r[1];
  assign sram_write_enable_c0 = we_n_r[2];
  assign sram_waddr_a         = waddr_r[0];
  assign sram_waddr_b         = waddr_r[1];
  assign sram_waddr_c         = waddr_r[2];
  assign busy                 = busy_r;
  assign tpu_done             = done_r;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl. Stimulus pushes the expected feed
// addresses, writeback rows, done latency and run length of each run; a
// monitor sampling 1 time unit after each rising edge pops and compares.
module tb_tpu_seq_ctrl;

  localparam int LAST_CNT = 41;
  localparam int FEED_N   = 27;

  logic       clk = 1'b0;
  logic       srstn, tpu_start, stall;
  logic [9:0] raddr_w0, raddr_w1, raddr_d0, raddr_d1;
  logic       feed_valid, we_a, we_b, we_c, busy, tpu_done;
  logic [5:0] waddr_a, waddr_b, waddr_c;
  logic [15:0] perf_cycles;

  tpu_seq_ctrl dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .stall(stall),
    .sram_raddr_w0(raddr_w0), .sram_raddr_w1(raddr_w1),
    .sram_raddr_d0(raddr_d0), .sram_raddr_d1(raddr_d1),
    .feed_valid(feed_valid),
    .sram_write_enable_a0(we_a), .sram_write_enable_b0(we_b),
    .sram_write_enable_c0(we_c),
    .sram_waddr_a(waddr_a), .sram_waddr_b(waddr_b), .sram_waddr_c(waddr_c),
    .busy(busy), .tpu_done(tpu_done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard queues; write entries are cnt*256 + address.
  int exp_feed[$];
  int wq0[$], wq1[$], wq2[$];
  int exp_lat[$];
  int exp_perf[$];

  // Reference model state (spec level: run active, cnt, edges since start).
  bit   run_active = 1'b0;
  int   mcnt = 0;
  int   edges = 0;
  int   overlap = 0;
  int   done_cnt = 0;
  bit   prev_active, stalled_edge;
  logic [9:0] raddr_prev = '0;
  logic done_prev = 1'b0;
  int   pend[42];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_write(input int b, input logic we_n, input logic [5:0] wa);
    int e;
    if (we_n == 1'b0) begin
      e = -1;
      if (b == 0 && wq0.size() > 0) e = wq0.pop_front();
      else if (b == 1 && wq1.size() > 0) e = wq1.pop_front();
      else if (b == 2 && wq2.size() > 0) e = wq2.pop_front();
      if (e < 0) begin
        chk($sformatf("wr%0d_unexpected", b), 1, 0);
      end else begin
        chk($sformatf("wr%0d_cnt", b), mcnt, e / 256);
        chk($sformatf("wr%0d_addr", b), int'(wa), e % 256);
      end
    end
  endtask

  // Monitor: advance the reference model by one edge, then compare.
  always @(posedge clk) begin
    #1;
    if (!srstn) begin
      run_active = 1'b0;
      done_prev  = 1'b0;
      raddr_prev = '0;
    end else begin
      prev_active  = run_active;
      stalled_edge = prev_active && stall;
      if (!prev_active && tpu_start) begin
        run_active = 1'b1;
        mcnt = 0;
        edges = 0;
        overlap = 0;
      end else begin
        edges++;
        if (prev_active && !stall) begin
          if (mcnt == LAST_CNT) run_active = 1'b0;
          else mcnt++;
        end
      end
      chk("busy", busy, run_active);
      chk("raddr_w0", raddr_w0, (run_active && mcnt < FEED_N) ? mcnt : 0);
      chk("raddr_w1", raddr_w1, (run_active && mcnt < FEED_N) ? mcnt : 0);
      chk("raddr_d0", raddr_d0, (run_active && mcnt < FEED_N) ? mcnt : 0);
      chk("raddr_d1", raddr_d1, (run_active && mcnt < FEED_N) ? mcnt : 0);
      if (stalled_edge) chk("stall_strobes", {we_a, we_b, we_c}, 7);
      if (run_active) chk("done_low_in_run", tpu_done, 0);
      if (!we_a && !we_b) overlap++;
      chk_write(0, we_a, waddr_a);
      chk_write(1, we_b, waddr_b);
      chk_write(2, we_c, waddr_c);
      if (feed_valid) begin
        if (exp_feed.size() == 0) chk("feed_unexpected", 1, 0);
        else chk("feed_addr", int'(raddr_prev), exp_feed.pop_front());
      end
      if (tpu_done && !done_prev) begin
        if (exp_lat.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_latency", edges, exp_lat.pop_front());
          chk("perf_cycles", perf_cycles, exp_perf.pop_front());
          chk("overlap_ab", overlap, 7);
        end
        done_cnt++;
      end
      raddr_prev = raddr_w0;
      done_prev  = tpu_done;
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_raddr"}, {raddr_w0, raddr_w1, raddr_d0, raddr_d1}, 0);
    chk({tag, "_feed_valid"}, feed_valid, 0);
    chk({tag, "_we"}, {we_a, we_b, we_c}, 7);
    chk({tag, "_waddr"}, {waddr_a, waddr_b, waddr_c}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, tpu_done, 0);
    chk({tag, "_perf"}, perf_cycles, 0);
  endtask

  // One run: push expectations, pulse start, play the stall plan in pend[].
  task automatic do_run(input bit dup_start, input int reset_at);
    int total = 0;
    int start_done;
    bit dup_sent = 1'b0;
    bit aborted = 1'b0;
    foreach (pend[i]) total += pend[i];
    for (int i = 0; i < FEED_N; i++) exp_feed.push_back(i);
    for (int i = 0; i < 15; i++) begin
      wq0.push_back((11 + i) * 256 + i);
      wq1.push_back((19 + i) * 256 + i);
      wq2.push_back((27 + i) * 256 + i);
    end
    exp_lat.push_back(43 + total);
`ifdef TPU_SEQ_PERF_EN
    exp_perf.push_back(42 + total);
`else
    exp_perf.push_back(0);
`endif
    start_done = done_cnt;
    @(negedge clk);
    tpu_start = 1'b1;
    stall = 1'($urandom_range(0, 1));
    for (int i = 0; i < 200 && done_cnt == start_done && !aborted; i++) begin
      @(negedge clk);
      tpu_start = 1'b0;
      if (run_active && pend[mcnt] > 0) begin
        stall = 1'b1;
        pend[mcnt]--;
      end else begin
        stall = run_active ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (dup_start && !dup_sent && run_active && mcnt == 10) begin
        tpu_start = 1'b1;
        dup_sent = 1'b1;
      end
      if (reset_at >= 0 && run_active && mcnt == reset_at) begin
        srstn = 1'b0;
        stall = 1'b0;
        #1;
        chk_reset_values("async_reset");
        exp_feed.delete(); wq0.delete(); wq1.delete(); wq2.delete();
        exp_lat.delete(); exp_perf.delete();
        foreach (pend[k]) pend[k] = 0;
        @(negedge clk);
        srstn = 1'b1;
        aborted = 1'b1;
      end
    end
    stall = 1'b0;
    if (!aborted) begin
      chk("done_seen", int'(done_cnt != start_done), 1);
      @(negedge clk);
      chk("feed_left", exp_feed.size(), 0);
      chk("writes_left", wq0.size() + wq1.size() + wq2.size(), 0);
    end
    foreach (pend[k]) pend[k] = 0;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
    end
    stall = 1'b0;
  endtask

  initial begin
    srstn = 1'b0;
    tpu_start = 1'b0;
    stall = 1'b0;
    foreach (pend[k]) pend[k] = 0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    srstn = 1'b1;
    @(negedge clk);

    do_run(1'b0, -1);            // plain run
    pend[20] = 5;
    do_run(1'b0, -1);            // 5-cycle stall at cnt 20
    do_run(1'b1, -1);            // start repeated at cnt 10
    do_run(1'b0, 30);            // reset at cnt 30
    do_run(1'b0, -1);            // clean run after reset
    do_run(1'b0, -1);            // restart straight from DONE
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < $urandom_range(0, 3); s++) begin
        pend[$urandom_range(0, LAST_CNT)] += $urandom_range(1, 6);
      end
      do_run(1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
- Sequencer for the 8x8 systolic-array TPU datapath.
- On a start pulse it issues one shared read-address stream to the four input SRAMs (weight w0/w1, data d0/d1) and marks when the read data is valid for the array.
- It then schedules writeback of the 15 anti-diagonal result rows of each of the 3 batches into output SRAMs a/b/c, and raises a done flag.
- It sits between tpu_top's datapath and the SRAM ports, replacing ad-hoc counters.

Parameters:
- ARRAY_SIZE, 8, PE rows/cols; each batch yields 2*ARRAY_SIZE-1 diagonal rows.
- BATCH, 3, number of matrix pairs per run (fixed to 3 output SRAMs).
- SKEW, 3, extra input words caused by row skew; FEED_LEN = ARRAY_SIZE*BATCH+SKEW = 27.
- WB_START, 11, run-counter value at which batch 0 writeback begins.
- IN_AW, 10, input SRAM address width.
- OUT_AW, 6, output SRAM address width.

Ports:
- clk  in  1  clock, rising edge.
- srstn  in  1  reset, asynchronous, active-low.
- tpu_start  in  1  one-cycle start pulse.
- stall  in  1  freeze request from the datapath.
- sram_raddr_w0, sram_raddr_w1, sram_raddr_d0, sram_raddr_d1  out  IN_AW each  read address, all four identical.
- feed_valid  out  1  rdata on the input SRAMs is a valid feed word this cycle.
- sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0  out  1 each  active-low write strobes for batches 0, 1, 2.
- sram_waddr_a, sram_waddr_b, sram_waddr_c  out  OUT_AW each  write address; also the diagonal index the datapath muxes out.
- busy  out  1  run in progress.
- tpu_done  out  1  level; set at end of run, cleared by the next accepted start.
- perf_cycles  out  16  run length in cycles (see Optional Feature).

Behaviour:
- All outputs registered.
- Reset values: addresses 0, write enables 1, feed_valid 0, busy 0, tpu_done 0, perf_cycles 0. Reset mid-run aborts immediately to IDLE.
- States:
  - IDLE: go to RUN on tpu_start; cnt <= 0.
  - RUN: cnt advances by 1 per non-stalled cycle; go to DONE after the cycle with cnt = LAST = WB_START + (BATCH-1)*ARRAY_SIZE + 2*ARRAY_SIZE - 2 = 41.
  - DONE: tpu_done = 1; tpu_start returns to RUN and clears tpu_done in the same edge.
- tpu_start is ignored while in RUN.
- Feed:
  - While in RUN with cnt < FEED_LEN, raddr = cnt; otherwise raddr = 0.
  - The SRAM has 1-cycle read latency, so feed_valid = the previous cycle's (RUN && cnt < FEED_LEN && !stall). It is high for exactly 27 cycles per run when there are no stalls.
- Writeback, per batch b (0..2):
  - Window is cnt in [WB_START+8b, WB_START+8b+14], i.e. c0: 11..25, c1: 19..33, c2: 27..41.
  - In the window: write enable b = 0 and waddr = cnt - (WB_START+8b), giving addresses 0..14 in order.
  - Outside the window: write enable = 1 and waddr holds its last value.
  - Windows overlap; simultaneous writes to different SRAMs are legal and required.
- Stall:
  - While stall = 1, cnt and all addresses hold, all write enables are forced to 1, and feed_valid drops one cycle later.
  - On release, the sequence resumes exactly where it stopped. No write is duplicated or lost.
  - A stall asserted in IDLE or DONE has no effect.
- busy = 1 exactly when in RUN.
- Without stalls, tpu_done rises 43 clock edges after the edge that samples tpu_start.

Optional Feature:
- TPU_SEQ_PERF_EN defined:
  - A 16-bit counter clears on the accepted start and increments every RUN cycle, including stalled cycles.
  - It saturates at 0xFFFF.
  - It is copied to perf_cycles on entry to DONE and held until the next start.
- TPU_SEQ_PERF_EN undefined: no counter is built and perf_cycles is tied to 0.

Test Plan:
- Reset then start pulse, no stall:
  - raddr steps 0..26.
  - feed_valid is high for 27 cycles, lagging raddr by 1.
  - tpu_done rises 43 edges after start; perf_cycles = 42 when the feature is enabled.
- Writeback check:
  - c0 write strobe low for cnt 11..25 with waddr 0..14.
  - c1 low for cnt 19..33.
  - c2 low for cnt 27..41.
  - The overlap at cnt 19..25 shows both a0 and b0 low.
- Stall for 5 cycles at cnt = 20:
  - Addresses freeze and all write strobes are high for those 5 cycles.
  - c0 still writes each of 0..14 exactly once.
  - tpu_done rises 48 edges after start; perf_cycles = 47.
- Second tpu_start at cnt = 10: ignored, timing identical to the first scenario.
- srstn pulled low at cnt = 30:
  - All outputs return to reset values asynchronously.
  - A new start then produces a full, clean run.
- Start asserted while in DONE: tpu_done clears on the same edge and the run repeats with identical results.
